direct_mapped_cache: RTL and testbench
======================================

Name: direct_mapped_cache

Overview:
Blocking, direct-mapped, write-through, no-write-allocate cache with one 32-bit word per line. It sits directly downstream of the processor core's dcache/icache ports: it consumes addr/re/we/din, returns dout and drives the core's stall input. Misses and all writes go to main memory over a valid/ready request channel and a valid response channel. One instance serves data and one serves instructions (instruction side ties cpu_we to 0).

Parameters:
LINES, 64, number of lines; power of two, at least 2. IDX = log2(LINES).
ADDR_W, 32, byte address width.

Ports:
clk  input  1  sole clock; all state on rising edge
reset  input  1  asynchronous, active-low reset (asserted at 0)
cpu_addr  input  ADDR_W  byte address; bits [1:0] ignored
cpu_re  input  1  read request
cpu_we  input  4  byte write enables; nonzero = write request
cpu_din  input  32  write data
cpu_dout  output  32  read data
stall  output  1  core must hold its request outputs while 1
mem_req_valid  output  1  memory request valid
mem_req_ready  input  1  memory accepts request
mem_req_rw  output  1  0 = read, 1 = write
mem_req_addr  output  ADDR_W  word-aligned address ([1:0]=0)
mem_req_data  output  32  write data
mem_req_mask  output  4  write byte mask
mem_resp_valid  input  1  read response valid
mem_resp_data  input  32  read response data

Behaviour:
- Address split: index = addr[IDX+1:2], tag = addr[ADDR_W-1:IDX+2]. Arrays: valid[LINES] (reset), tag[LINES], data[LINES] (not reset).
- Reset (async, level): state=IDLE, all valid bits 0, request registers 0. Outputs during and after reset: stall=0, mem_req_valid=0, mem_req_rw=0, mem_req_addr=0, mem_req_data=0, mem_req_mask=0, cpu_dout=0.
- Acceptance: a request is accepted on a rising edge when stall=0 and (cpu_re or cpu_we!=0) in an accepting state. addr, din, we and the read/write flag are latched into request registers. If cpu_re and cpu_we!=0 together, the write wins and the read is ignored.
- FSM states: IDLE, CHECK, RD_REQ, RD_WAIT, WR_REQ.
- IDLE: stall=0; accepts a request -> CHECK.
- CHECK, read hit (valid and tag match): cpu_dout = data[idx] and stall=0 in this cycle, so latency is 1 cycle after acceptance. A new request can be accepted in the same cycle -> CHECK, otherwise -> IDLE.
- CHECK, read miss: stall=1 -> RD_REQ.
- CHECK, write: stall=1. On a hit, data[idx] bytes are merged per the we mask at this edge; on a miss there is no allocation. Next state WR_REQ.
- RD_REQ: stall=1, mem_req_valid=1, rw=0, address = request address word-aligned. On mem_req_ready -> RD_WAIT.
- RD_WAIT: stall=1. On mem_resp_valid: data = resp_data, tag written, valid=1, -> CHECK, which then hits (miss latency = memory latency + 2 cycles after acceptance).
- WR_REQ: mem_req_valid=1, rw=1, data = latched din, mask = latched we. stall = !mem_req_ready (combinational). On ready, a new request can be accepted in the same cycle -> CHECK, otherwise -> IDLE.
- cpu_dout = hit ? data[idx] : 0, evaluated in CHECK; it is 0 in every other state.
- mem_req_* hold stable while mem_req_valid=1 and ready=0. mem_req_valid is 0 outside RD_REQ and WR_REQ, and all mem_req_* payload outputs are 0 when valid=0.
- mem_resp_valid outside RD_WAIT is ignored.
- Reset mid-transaction abandons it. The line is not filled, and any late response is ignored.
- Reads to a line are never served from a pending write buffer (there is none); a write completes before the next request is accepted.

Test Plan:
1. Reset, read 0x100; memory ready=1, response 0xDEADBEEF three cycles later -> one mem read at 0x100; stall=1 until the fill; then CHECK gives dout=0xDEADBEEF with stall=0.
2. Read 0x100 again -> dout=0xDEADBEEF one cycle after acceptance; no mem_req_valid; stall stays 0.
3. Write 0x100, we=4'b0011, din=0x0000CAFE, ready delayed 2 cycles -> mem write with mask 0011 and data 0x0000CAFE held stable; stall released the cycle ready=1; next read of 0x100 hits 0xDEADCAFE.
4. LINES=64: read 0x200 (same index as 0x100) -> miss, line replaced; then read 0x100 -> miss with a new memory read.
5. Write miss to 0x300 -> mem write issued; following read of 0x300 misses (no allocation). Also drive re and we=4'b1111 together -> only a write is issued.
6. Assert reset (0) during RD_WAIT -> stall and mem_req_valid drop to 0 immediately; a late mem_resp_valid is ignored; after release, a read of the same address misses.

Source files
------------

// File: rtl/direct_mapped_cache.sv
// rtl/direct_mapped_cache.sv - blocking direct-mapped write-through, no-write-allocate cache, one word per line
module direct_mapped_cache #(
    parameter int LINES  = 64,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_re,
    input  logic [3:0]        cpu_we,
    input  logic [31:0]       cpu_din,
    output logic [31:0]       cpu_dout,
    output logic              stall,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_rw,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [31:0]       mem_req_data,
    output logic [3:0]        mem_req_mask,
    input  logic              mem_resp_valid,
    input  logic [31:0]       mem_resp_data
);

    localparam int IDX   = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX - 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_RD_REQ,
        S_RD_WAIT,
        S_WR_REQ
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic [ADDR_W-3:0]   r_waddr;
    logic [31:0]         r_din;
    logic [3:0]          r_we;
    logic                r_is_wr;

    logic [LINES-1:0]    r_valid;
    logic [TAG_W-1:0]    r_tag  [LINES];
    logic [31:0]         r_data [LINES];

    logic [IDX-1:0]      w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic                w_hit;
    logic                w_accept;
    logic                w_fill;
    logic                w_wr_hit;
    logic [31:0]         w_merged;
    logic                w_unused_addr_lsbs;

    // byte offset never reaches the line lookup
    assign w_unused_addr_lsbs = &{1'b0, cpu_addr[1:0]};

    assign w_idx    = r_waddr[IDX-1:0];
    assign w_tag    = r_waddr[ADDR_W-3:IDX];
    assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_accept = !stall && (cpu_re || (cpu_we != 4'b0000));
    assign w_fill   = (r_state == S_RD_WAIT) && mem_resp_valid;
    assign w_wr_hit = (r_state == S_CHECK) && r_is_wr && w_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_next = S_CHECK;
            S_CHECK: begin
                if (r_is_wr)    w_next = S_WR_REQ;
                else if (w_hit) w_next = w_accept ? S_CHECK : S_IDLE;
                else            w_next = S_RD_REQ;
            end
            S_RD_REQ:  if (mem_req_ready)  w_next = S_RD_WAIT;
            S_RD_WAIT: if (mem_resp_valid) w_next = S_CHECK;
            S_WR_REQ:  if (mem_req_ready)  w_next = w_accept ? S_CHECK : S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // stall leaving WR_REQ follows ready so the next request overlaps the handshake
    always_comb begin
        cpu_dout      = '0;
        stall         = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_rw    = 1'b0;
        mem_req_addr  = '0;
        mem_req_data  = '0;
        mem_req_mask  = '0;
        case (r_state)
            S_CHECK: begin
                stall    = r_is_wr || !w_hit;
                cpu_dout = w_hit ? r_data[w_idx] : '0;
            end
            S_RD_REQ: begin
                stall         = 1'b1;
                mem_req_valid = 1'b1;
                mem_req_addr  = {r_waddr, 2'b00};
            end
            S_RD_WAIT: begin
                stall = 1'b1;
            end
            S_WR_REQ: begin
                stall         = !mem_req_ready;
                mem_req_valid = 1'b1;
                mem_req_rw    = 1'b1;
                mem_req_addr  = {r_waddr, 2'b00};
                mem_req_data  = r_din;
                mem_req_mask  = r_we;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_waddr <= '0;
            r_din   <= '0;
            r_we    <= '0;
            r_is_wr <= 1'b0;
        end else if (w_accept) begin
            r_waddr <= cpu_addr[ADDR_W-1:2];
            r_din   <= cpu_din;
            r_we    <= cpu_we;
            r_is_wr <= (cpu_we != 4'b0000);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
        end else if (w_fill) begin
            r_valid[w_idx] <= 1'b1;
        end
    end

    always_comb begin
        w_merged = r_data[w_idx];
        for (int b = 0; b < 4; b++) begin
            if (r_we[b]) w_merged[8*b +: 8] = r_din[8*b +: 8];
        end
    end

    // tag/data carry no reset; a line is only trusted once its valid bit is set
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tag[w_idx]  <= w_tag;
            r_data[w_idx] <= mem_resp_data;
        end else if (w_wr_hit) begin
            r_data[w_idx] <= w_merged;
        end
    end

endmodule

// File: tb/tb_direct_mapped_cache.sv
// tb/tb_direct_mapped_cache.sv - randomized bench for direct_mapped_cache against a word-level memory/residency model
module tb_direct_mapped_cache;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cpu_addr;
    logic        cpu_re;
    logic [3:0]  cpu_we;
    logic [31:0] cpu_din;
    logic [31:0] cpu_dout;
    logic        stall;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_rw;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_data;
    logic [3:0]  mem_req_mask;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    always #5 clk = ~clk;

    direct_mapped_cache #(.LINES(64), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_re(cpu_re), .cpu_we(cpu_we),
        .cpu_din(cpu_din), .cpu_dout(cpu_dout), .stall(stall), .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
        .mem_req_data(mem_req_data), .mem_req_mask(mem_req_mask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );

    int n_checks = 0;
    int n_errors = 0;

    // memory contents by word address; the cache is coherent with it, so a hit returns mem_m[w]
    bit [31:0] mem_m [bit [29:0]];
    bit        present  [64];
    bit [29:0] resident [64];
    bit        last_hit;
    logic [31:0] last_dout;

    bit          chk_en = 1'b0;
    bit          chk_dout;
    logic        exp_stall, exp_valid, exp_rw;
    logic [31:0] exp_addr, exp_data, exp_dout;
    logic [3:0]  exp_mask;

    logic [31:0] ra;
    int          rk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%08h expected=%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("stall", 32'(stall), 32'(exp_stall));
            check("mem_req_valid", 32'(mem_req_valid), 32'(exp_valid));
            check("mem_req_rw", 32'(mem_req_rw), 32'(exp_rw));
            check("mem_req_addr", mem_req_addr, exp_addr);
            check("mem_req_data", mem_req_data, exp_data);
            check("mem_req_mask", 32'(mem_req_mask), 32'(exp_mask));
            if (chk_dout) check("cpu_dout", cpu_dout, exp_dout);
        end
        last_dout = cpu_dout;
    end

    task automatic set_exp(input logic st, input logic v, input logic rw, input logic [31:0] ad,
                           input logic [31:0] d, input logic [3:0] m, input logic [31:0] dout, input bit cd);
        exp_stall = st; exp_valid = v; exp_rw = rw; exp_addr = ad;
        exp_data = d; exp_mask = m; exp_dout = dout; chk_dout = cd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic junk_cpu();
        cpu_re   = 1'($urandom);
        cpu_we   = 4'($urandom);
        cpu_addr = $urandom;
        cpu_din  = $urandom;
    endtask

    task automatic junk_resp();
        mem_resp_valid = 1'($urandom);
        mem_resp_data  = $urandom;
    endtask

    task automatic touch(input bit [29:0] w);
        if (!mem_m.exists(w)) mem_m[w] = $urandom;
    endtask

    task automatic mem_write(input bit [29:0] w, input logic [3:0] we, input logic [31:0] din);
        bit [31:0] t;
        t = mem_m[w];
        for (int b = 0; b < 4; b++) if (we[b]) t[8*b +: 8] = din[8*b +: 8];
        mem_m[w] = t;
    endtask

    task automatic idle_cycle();
        cpu_re = 1'b0; cpu_we = 4'b0000; cpu_addr = $urandom; cpu_din = $urandom;
        tick();
        junk_resp();
        mem_req_ready = 1'($urandom);
        set_exp(0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    // Presents one request in a cycle where stall is expected low and walks it to its
    // last cycle (stall low again); the caller drives the cpu inputs of that last cycle.
    task automatic do_req(input logic [31:0] a, input bit re, input logic [3:0] we,
                          input logic [31:0] din, input int rdly, input int rsp);
        bit [29:0] w;
        int        idx;
        int        d;
        bit        hit;
        w   = a[31:2];
        idx = int'(w[5:0]);
        touch(w);
        hit = present[idx] && (resident[idx] == w);
        last_hit = hit;
        cpu_addr = a; cpu_re = re; cpu_we = we; cpu_din = din;
        tick();
        junk_cpu(); junk_resp();
        mem_req_ready = 1'($urandom);
        if (we != 4'b0000) begin
            set_exp(1, 0, 0, 0, 0, 0, 0, 0);
            d = (rdly < 0) ? $urandom_range(0, 3) : rdly;
            repeat (d) begin
                tick(); junk_cpu(); junk_resp();
                mem_req_ready = 1'b0;
                set_exp(1, 1, 1, {w, 2'b00}, din, we, 0, 1);
            end
            tick(); junk_resp();
            mem_req_ready = 1'b1;
            set_exp(0, 1, 1, {w, 2'b00}, din, we, 0, 1);
            mem_write(w, we, din);
        end else if (hit) begin
            set_exp(0, 0, 0, 0, 0, 0, mem_m[w], 1);
        end else begin
            set_exp(1, 0, 0, 0, 0, 0, 0, 1);
            d = (rdly < 0) ? $urandom_range(0, 2) : rdly;
            repeat (d) begin
                tick(); junk_cpu(); junk_resp();
                mem_req_ready = 1'b0;
                set_exp(1, 1, 0, {w, 2'b00}, 0, 0, 0, 1);
            end
            tick(); junk_cpu(); junk_resp();
            mem_req_ready = 1'b1;
            set_exp(1, 1, 0, {w, 2'b00}, 0, 0, 0, 1);
            d = (rsp < 0) ? $urandom_range(0, 3) : rsp;
            repeat (d) begin
                tick(); junk_cpu();
                mem_req_ready = 1'($urandom);
                mem_resp_valid = 1'b0; mem_resp_data = $urandom;
                set_exp(1, 0, 0, 0, 0, 0, 0, 1);
            end
            tick(); junk_cpu();
            mem_req_ready = 1'($urandom);
            mem_resp_valid = 1'b1; mem_resp_data = mem_m[w];
            set_exp(1, 0, 0, 0, 0, 0, 0, 1);
            present[idx]  = 1'b1;
            resident[idx] = w;
            tick(); junk_resp();
            mem_req_ready = 1'($urandom);
            set_exp(0, 0, 0, 0, 0, 0, mem_m[w], 1);
        end
    endtask

    initial begin
        reset = 1'b0;
        cpu_addr = '0; cpu_re = 1'b0; cpu_we = '0; cpu_din = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        foreach (present[i]) present[i] = 1'b0;
        set_exp(0, 0, 0, 0, 0, 0, 0, 1);
        chk_en = 1'b1;
        repeat (3) tick();
        reset = 1'b1;

        mem_m[30'h40] = 32'hDEADBEEF;
        do_req(32'h100, 1, 4'b0000, 0, 0, 2);
        idle_cycle();
        check("t1_fill_dout", last_dout, 32'hDEADBEEF);
        check("t1_was_miss", 32'(last_hit), 0);

        do_req(32'h100, 1, 4'b0000, 0, -1, -1);
        idle_cycle();
        check("t2_hit_dout", last_dout, 32'hDEADBEEF);
        check("t2_was_hit", 32'(last_hit), 1);

        do_req(32'h100, 0, 4'b0011, 32'h0000CAFE, 2, -1);
        check("t3_model_merge", mem_m[30'h40], 32'hDEADCAFE);
        do_req(32'h100, 1, 4'b0000, 0, -1, -1);
        idle_cycle();
        check("t3_merged_dout", last_dout, 32'hDEADCAFE);

        do_req(32'h200, 1, 4'b0000, 0, -1, -1);
        check("t4_conflict_miss", 32'(last_hit), 0);
        do_req(32'h100, 1, 4'b0000, 0, -1, -1);
        check("t4_refetch_miss", 32'(last_hit), 0);
        idle_cycle();
        check("t4_refetch_dout", last_dout, 32'hDEADCAFE);

        do_req(32'h300, 0, 4'b1111, 32'h12345678, -1, -1);
        do_req(32'h300, 1, 4'b0000, 0, -1, -1);
        check("t5_no_allocate", 32'(last_hit), 0);
        idle_cycle();
        check("t5_written_dout", last_dout, 32'h12345678);
        do_req(32'h500, 1, 4'b1111, 32'hA5A5A5A5, -1, -1);
        idle_cycle();

        do_req(32'h104, 1, 4'b0000, 0, -1, -1);
        touch(30'h100);
        cpu_addr = 32'h400; cpu_re = 1'b1; cpu_we = 4'b0000;
        tick(); junk_cpu();
        mem_resp_valid = 1'b0; mem_req_ready = 1'b0;
        set_exp(1, 0, 0, 0, 0, 0, 0, 1);
        tick(); junk_cpu();
        mem_req_ready = 1'b1;
        set_exp(1, 1, 0, 32'h400, 0, 0, 0, 1);
        tick(); junk_cpu();
        mem_req_ready = 1'b0;
        set_exp(1, 0, 0, 0, 0, 0, 0, 1);
        #2;
        reset = 1'b0;
        set_exp(0, 0, 0, 0, 0, 0, 0, 1);
        foreach (present[i]) present[i] = 1'b0;
        tick();
        cpu_re = 1'b0; cpu_we = 4'b0000;
        mem_resp_valid = 1'b1; mem_resp_data = 32'h0BAD0BAD;
        tick();
        reset = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        do_req(32'h104, 1, 4'b0000, 0, -1, -1);
        check("t6_valid_cleared", 32'(last_hit), 0);
        do_req(32'h400, 1, 4'b0000, 0, -1, -1);
        check("t6_no_late_fill", 32'(last_hit), 0);

        for (int i = 0; i < 300; i++) begin
            rk = $urandom_range(0, 9);
            if (rk < 8) ra = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            else        ra = $urandom;
            rk = $urandom_range(0, 9);
            if (rk < 5)      do_req(ra, 1, 4'b0000, $urandom, -1, -1);
            else if (rk < 8) do_req(ra, 1'($urandom), 4'($urandom_range(1, 15)), $urandom, -1, -1);
            else             idle_cycle();
        end
        idle_cycle();
        idle_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
